stq_alloc_ctrl: RTL
===================

Name: stq_alloc_ctrl

Overview:
- Pointer and allocation controller for the 64-entry store-queue address buffer array. It is the driver side of that array's per-entry control interface.
- Generates the one-hot wrt0_en/wrt1_en, passe_en and free_en vectors.
- Tracks three circular pointers over the entries: alloc (tail), retire, drain (head).
- Handles exception flush of allocated-but-unretired stores. Sits between rename/dispatch, the retire unit and the cache store-drain path.

Parameters:
BUF_COUNT, 64, number of store-queue entries (power of two)
PTR_W, 6, log2(BUF_COUNT); internal pointers are PTR_W+1 bits (wrap bit)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stallA  in  1  suppress allocation this cycle
excpt  in  1  flush all allocated, non-retired entries
alloc0_req  in  1  request one entry on slot 0
alloc1_req  in  1  request one entry on slot 1
alloc_gnt  out  1  all requested entries granted this cycle
alloc0_idx  out  PTR_W  entry index for slot 0
alloc1_idx  out  PTR_W  entry index for slot 1
wrt0_en  out  BUF_COUNT  one-hot write enable, slot 0
wrt1_en  out  BUF_COUNT  one-hot write enable, slot 1
retire_cnt  in  2  stores retiring this cycle (0..2)
passe_en  out  BUF_COUNT  mark retired entries passe
drain_vld  out  1  oldest retired entry ready to write to cache
drain_idx  out  PTR_W  index of that entry
drain_ack  in  1  cache accepted drain_idx
free_en  out  BUF_COUNT  return entries to free
count  out  PTR_W+1  occupied entries (alloc_ptr - drain_ptr)
full  out  1  count==BUF_COUNT
empty  out  1  count==0
err  out  1  sticky: retire_cnt exceeded unretired entries

Behaviour:
- Reset (async): all pointers 0; err=0; count=0; empty=1; full=0.
- All enable vectors are combinational from current pointers and inputs. All enable vectors are 0 during reset.
- Pointer updates occur on posedge clk.
- Allocation:
  - n = alloc0_req + alloc1_req.
  - alloc_gnt=1 iff n>0, ~stallA, ~excpt and (BUF_COUNT - count) >= n.
  - Grant is all-or-nothing.
  - alloc0_idx = alloc_ptr; alloc1_idx = alloc_ptr + alloc0_req (mod BUF_COUNT).
  - When granted, wrt0_en/wrt1_en is the one-hot of the respective idx for each requesting slot.
  - alloc_ptr += n next cycle.
- Retire:
  - r = retire_cnt clamped to the unretired count (alloc_ptr - retire_ptr).
  - passe_en is one-hot-or of retire_ptr .. retire_ptr+r-1; retire_ptr += r.
  - If retire_cnt > unretired count: err<=1 (sticky until rst). Only r entries are retired.
  - retire_cnt==3 is treated as 2 and sets err.
- Drain:
  - drain_vld = (retire_ptr != drain_ptr); drain_idx = drain_ptr.
  - drain_vld & drain_ack: free_en[drain_ptr]=1, drain_ptr += 1.
  - drain_ack without drain_vld is ignored.
- Exception:
  - Retire in the same cycle is honoured first, giving new retire pointer R'.
  - free_en additionally asserts for every entry in [R', alloc_ptr). alloc_ptr <= R' next cycle.
  - No allocation in the excpt cycle.
  - Drain is unaffected; retired entries survive the flush.
- Simultaneous events:
  - A drain freeing an entry does not increase allocation capacity until the next cycle. No same-cycle bypass.
  - Alloc and retire in the same cycle touch disjoint entries.
  - Pointer wrap uses the PTR_W+1 wrap bit: full = (alloc_ptr == drain_ptr with wrap bit differing).
- Invariant: drain_ptr <= retire_ptr <= alloc_ptr (modular, with wrap bit).

Optional Feature:
STQ_ALLOC_PERF_EN:
- When defined, adds output perf_full_stall [31:0]: a saturating counter.
- Increments each cycle with n>0 & ~stallA & ~excpt & ~alloc_gnt.
- Reset to 0 by rst.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then alloc0+alloc1 for 32 cycles -> alloc_gnt=1 each cycle, indices 0..63 in order. Next cycle full=1, count=64; a further single alloc gives alloc_gnt=0 and no wrt*_en bit.
- Fill 4 entries, retire_cnt=2 -> passe_en=0x3, drain_vld=1, drain_idx=0. Then drain_ack for 2 cycles -> free_en=0x1 then 0x2, count=2.
- Fill 6 entries, retire_cnt=1 with excpt in the same cycle -> passe_en=0x1 and free_en=0x3E. Next cycle count=1, next alloc0_idx=1.
- Wrap: retire and drain 60 of 64 entries, then alloc 4 -> indices 0..3, count=8, full=0, empty=0.
- With 1 unretired entry, retire_cnt=2 -> passe_en has exactly one bit set, err=1 and remains 1 until rst.
- With STQ_ALLOC_PERF_EN, hold full plus alloc0_req for 10 cycles -> perf_full_stall=10. Assert rst mid-count -> 0 immediately (asynchronous).

Source files
------------

// File: rtl/stq_alloc_ctrl_if.sv
// Control bus between the store-queue pointer/allocation controller and rename, retire and drain.
// Defining STQ_ALLOC_PERF_EN adds the perf_full_stall counter output.
interface stq_alloc_ctrl_if #(
  parameter int BUF_COUNT = 64,
  parameter int PTR_W     = 6
);
  logic                 stallA;
  logic                 excpt;
  logic                 alloc0_req;
  logic                 alloc1_req;
  logic                 alloc_gnt;
  logic [PTR_W-1:0]     alloc0_idx;
  logic [PTR_W-1:0]     alloc1_idx;
  logic [BUF_COUNT-1:0] wrt0_en;
  logic [BUF_COUNT-1:0] wrt1_en;
  logic [1:0]           retire_cnt;
  logic [BUF_COUNT-1:0] passe_en;
  logic                 drain_vld;
  logic [PTR_W-1:0]     drain_idx;
  logic                 drain_ack;
  logic [BUF_COUNT-1:0] free_en;
  logic [PTR_W:0]       count;
  logic                 full;
  logic                 empty;
  logic                 err;
`ifdef STQ_ALLOC_PERF_EN
  logic [31:0]          perf_full_stall;
`endif

  modport master (
    input  stallA, excpt, alloc0_req, alloc1_req, retire_cnt, drain_ack,
    output alloc_gnt, alloc0_idx, alloc1_idx, wrt0_en, wrt1_en, passe_en,
    output drain_vld, drain_idx, free_en, count, full, empty, err
`ifdef STQ_ALLOC_PERF_EN
    , output perf_full_stall
`endif
  );

  modport slave (
    output stallA, excpt, alloc0_req, alloc1_req, retire_cnt, drain_ack,
    input  alloc_gnt, alloc0_idx, alloc1_idx, wrt0_en, wrt1_en, passe_en,
    input  drain_vld, drain_idx, free_en, count, full, empty, err
`ifdef STQ_ALLOC_PERF_EN
    , input perf_full_stall
`endif
  );
endinterface

// File: rtl/stq_alloc_ctrl.sv
// Store-queue alloc/retire/drain pointer controller driving the per-entry enable vectors.
// Defining STQ_ALLOC_PERF_EN adds a saturating count of capacity-stalled allocation cycles.
module stq_alloc_ctrl #(
  parameter int BUF_COUNT = 64,
  parameter int PTR_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  stq_alloc_ctrl_if.master bus
);
  localparam int            PW  = PTR_W + 1;
  localparam logic [PW-1:0] CAP = PW'(BUF_COUNT);

  logic [PW-1:0]        r_alloc_ptr;
  logic [PW-1:0]        r_retire_ptr;
  logic [PW-1:0]        r_drain_ptr;
  logic                 r_err;

  logic [PW-1:0]        w_count;
  logic [PW-1:0]        w_unret;
  logic [PW-1:0]        w_space;
  logic [1:0]           w_n;
  logic                 w_gnt;
  logic [PTR_W-1:0]     w_idx0;
  logic [PTR_W-1:0]     w_idx1;
  logic [1:0]           w_ret_req;
  logic [1:0]           w_ret_n;
  logic                 w_ret_ovf;
  logic [PW-1:0]        w_retire_nxt;
  logic [PW-1:0]        w_flush_len;
  logic                 w_drain_vld;
  logic                 w_drain_fire;
  logic [BUF_COUNT-1:0] w_wrt0;
  logic [BUF_COUNT-1:0] w_wrt1;
  logic [BUF_COUNT-1:0] w_passe;
  logic [BUF_COUNT-1:0] w_free;

  assign w_count      = r_alloc_ptr - r_drain_ptr;
  assign w_unret      = r_alloc_ptr - r_retire_ptr;
  assign w_space      = CAP - w_count;
  assign w_n          = {1'b0, bus.alloc0_req} + {1'b0, bus.alloc1_req};
  assign w_gnt        = (w_n != 2'd0) & ~bus.stallA & ~bus.excpt & (w_space >= PW'(w_n));
  assign w_idx0       = r_alloc_ptr[PTR_W-1:0];
  assign w_idx1       = r_alloc_ptr[PTR_W-1:0] + PTR_W'(bus.alloc0_req);
  assign w_ret_ovf    = (bus.retire_cnt == 2'd3) | (PW'(bus.retire_cnt) > w_unret);
  assign w_retire_nxt = r_retire_ptr + PW'(w_ret_n);
  assign w_flush_len  = r_alloc_ptr - w_retire_nxt;
  assign w_drain_vld  = (r_retire_ptr != r_drain_ptr);
  assign w_drain_fire = w_drain_vld & bus.drain_ack;

  // Retire request clamped to 2 and to the number of unretired entries
  always_comb begin
    w_ret_req = 2'd0;
    w_ret_n   = 2'd0;
    case (bus.retire_cnt)
      2'd3:    w_ret_req = 2'd2;
      default: w_ret_req = bus.retire_cnt;
    endcase
    if (PW'(w_ret_req) > w_unret) begin
      w_ret_n = w_unret[1:0];
    end else begin
      w_ret_n = w_ret_req;
    end
  end

  // Write, passe and free enables; the flush range [R', alloc) is measured from the post-retire pointer
  always_comb begin
    w_wrt0  = '0;
    w_wrt1  = '0;
    w_passe = '0;
    w_free  = '0;
    w_wrt0[w_idx0] = w_gnt & bus.alloc0_req;
    w_wrt1[w_idx1] = w_gnt & bus.alloc1_req;
    w_passe[r_retire_ptr[PTR_W-1:0]]         = (w_ret_n != 2'd0);
    w_passe[r_retire_ptr[PTR_W-1:0] + 1'b1]  = (w_ret_n == 2'd2);
    w_free[r_drain_ptr[PTR_W-1:0]]           = w_drain_fire;
    for (int i = 0; i < BUF_COUNT; i++) begin
      w_free[i] = w_free[i] | (bus.excpt &
                  ({1'b0, PTR_W'(i) - w_retire_nxt[PTR_W-1:0]} < w_flush_len));
    end
  end

  assign bus.alloc_gnt  = w_gnt & ~rst;
  assign bus.alloc0_idx = w_idx0;
  assign bus.alloc1_idx = w_idx1;
  assign bus.wrt0_en    = rst ? '0 : w_wrt0;
  assign bus.wrt1_en    = rst ? '0 : w_wrt1;
  assign bus.passe_en   = rst ? '0 : w_passe;
  assign bus.free_en    = rst ? '0 : w_free;
  assign bus.drain_vld  = w_drain_vld & ~rst;
  assign bus.drain_idx  = r_drain_ptr[PTR_W-1:0];
  assign bus.count      = w_count;
  assign bus.full       = (w_count == CAP);
  assign bus.empty      = (w_count == PW'(0));
  assign bus.err        = r_err;

  // Pointer state; an exception rewinds alloc to the post-retire pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc_ptr  <= PW'(0);
      r_retire_ptr <= PW'(0);
      r_drain_ptr  <= PW'(0);
      r_err        <= 1'b0;
    end else begin
      r_retire_ptr <= w_retire_nxt;
      r_drain_ptr  <= r_drain_ptr + PW'(w_drain_fire);
      r_err        <= r_err | w_ret_ovf;
      if (bus.excpt) begin
        r_alloc_ptr <= w_retire_nxt;
      end else if (w_gnt) begin
        r_alloc_ptr <= r_alloc_ptr + PW'(w_n);
      end else begin
        r_alloc_ptr <= r_alloc_ptr;
      end
    end
  end

`ifdef STQ_ALLOC_PERF_EN
  logic [31:0] r_perf;
  logic        w_stall_evt;

  assign w_stall_evt         = (w_n != 2'd0) & ~bus.stallA & ~bus.excpt & ~w_gnt;
  assign bus.perf_full_stall = r_perf;

  // Saturating count of cycles where allocation was refused for lack of space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= 32'd0;
    end else if (w_stall_evt && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end else begin
      r_perf <= r_perf;
    end
  end
`endif

endmodule
